niosii_mulx_seq: RTL

- Multi-cycle multiply sequencer for the Nios II micro CPU execute stage; a neighbour of the 32-bit low-product multiplier cell.
- Serves MUL, MULXUU, MULXSU and MULXSS by iterating four 16x16 unsigned partial products through one internal registered 16x16 multiplier.
- Sums the partial products into a 64-bit accumulator and applies signed correction to the high word.
- Stalls the pipeline while busy; returns the 32-bit result with a one-cycle done strobe.

---
 rtl/niosii_mulx_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/niosii_mulx_seq.sv
// niosii_mulx_seq: multi-cycle 32x32 multiply sequencer (MUL/MULXUU/MULXSU/MULXSS) built on one 16x16 cell
// Ports:
//   clk           single rising-edge clock
//   reset         asynchronous active-high reset
//   A_mul_start   request, sampled only in IDLE or DONE
//   A_mul_op      00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   A_mul_src1    operand a, latched at accept
//   A_mul_src2    operand b, latched at accept
//   A_mul_stall   pipeline stall while an operation is in flight
//   A_mul_done    one-cycle result-valid strobe
//   A_mul_result  32-bit result, held until the next done
module niosii_mulx_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        A_mul_start,
    input  logic [1:0]  A_mul_op,
    input  logic [31:0] A_mul_src1,
    input  logic [31:0] A_mul_src2,
    output logic        A_mul_stall,
    output logic        A_mul_done,
    output logic [31:0] A_mul_result
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] FIX   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    // only the output stage still holds a product: it is accumulated on this edge
    localparam logic [CELL_LATENCY-1:0] LAST = CELL_LATENCY'(1) << (CELL_LATENCY - 1);
    logic [2:0]              state;
    logic [1:0]              k;
    logic [1:0]              op;
    logic [31:0]             a;
    logic [31:0]             b;
    logic [63:0]             acc;
    logic [CELL_LATENCY-1:0] vld;
    logic [31:0]             pp [CELL_LATENCY];
    logic [1:0]              sh [CELL_LATENCY];
    logic                    accept;
    logic [15:0]             ma;
    logic [15:0]             mb;
    logic [63:0]             addend;
    logic [31:0]             fix_val;
    always_comb begin
        accept      = A_mul_start & (state == IDLE | state == DONE);
        A_mul_stall = accept | state == ISSUE | state == DRAIN | state == FIX;
        A_mul_done  = state == DONE;
        // k[0] selects the high half of a, k[1] the high half of b
        ma          = k[0] ? a[31:16] : a[15:0];
        mb          = k[1] ? b[31:16] : b[15:0];
        // shift tag counts 16-bit positions: 0, 1, 1, 2
        addend      = sh[CELL_LATENCY-1] == 2'd2 ? {pp[CELL_LATENCY-1], 32'b0} :
                      sh[CELL_LATENCY-1] == 2'd1 ? {16'b0, pp[CELL_LATENCY-1], 16'b0} :
                                                   {32'b0, pp[CELL_LATENCY-1]};
        // signed high word = unsigned high word minus the cross terms of negative operands
        fix_val     = op == 2'b00 ? acc[31:0] :
                      acc[63:32] - ((op[1] & a[31]) ? b : 32'd0)
                                 - ((op == 2'b11 && b[31]) ? a : 32'd0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            k            <= 2'd0;
            op           <= 2'd0;
            a            <= 32'd0;
            b            <= 32'd0;
            acc          <= 64'd0;
            vld          <= '0;
            A_mul_result <= 32'd0;
            for (int i = 0; i < CELL_LATENCY; i++) begin
                pp[i] <= 32'd0;
                sh[i] <= 2'd0;
            end
        end else begin
            vld[0] <= state == ISSUE;
            pp[0]  <= {16'b0, ma} * {16'b0, mb};
            sh[0]  <= {1'b0, k[0]} + {1'b0, k[1]};
            for (int i = 1; i < CELL_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                pp[i]  <= pp[i-1];
                sh[i]  <= sh[i-1];
            end
            if (accept)
                acc <= 64'd0;
            else if (vld[CELL_LATENCY-1])
                acc <= acc + addend;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a     <= A_mul_src1;
                        b     <= A_mul_src2;
                        op    <= A_mul_op;
                        k     <= 2'd0;
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    k     <= k + 2'd1;
                    state <= k == 2'd3 ? DRAIN : ISSUE;
                end
                DRAIN: state <= vld == LAST ? FIX : DRAIN;
                FIX: begin
                    A_mul_result <= fix_val;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
